// File: rtl/hd44780_led_indicator_if.sv
// Configuration/sync bus for the LED indicator block, plus the registered LED drive.
// Write handshake: cfg_we is a one-cycle valid with no ready (the block always accepts
// or rejects on the same edge); the outcome is reported by a one-cycle cfg_ack or cfg_err
// pulse in the following cycle, and the two are never high together.
interface hd44780_led_indicator_if #(
    parameter int NCHAN    = 4,
    parameter int PWM_BITS = 3
);
    logic                sync;
    logic                cfg_we;
    logic [3:0]          cfg_chan;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;
    logic                cfg_ack;
    logic                cfg_err;
    logic [NCHAN-1:0]    led;

    modport master (
        output sync, cfg_we, cfg_chan, cfg_mode, cfg_duty,
        input  cfg_ack, cfg_err, led
    );

    modport slave (
        input  sync, cfg_we, cfg_chan, cfg_mode, cfg_duty,
        output cfg_ack, cfg_err, led
    );
endinterface

// File: rtl/hd44780_led_indicator.sv
// Multi-channel LED driver: per-channel mode (off/steady/blink/heartbeat) gated by a
// shared PWM brightness counter, with a registered, polarity-corrected output.
`ifndef H4_TIMER_BITS
`define H4_TIMER_BITS 2
`endif

module hd44780_led_indicator #(
    parameter int               NCHAN      = 4,
    parameter int               PWM_BITS   = 3,
    parameter int               BLINK_BITS = `H4_TIMER_BITS + 4,
    parameter logic [NCHAN-1:0] ACTIVE_LOW = {NCHAN{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    hd44780_led_indicator_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STEADY = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_HEART  = 2'b11
    } mode_t;

    logic [PWM_BITS-1:0]   pwm_ctr;
    logic [BLINK_BITS-1:0] blink_ctr;
    mode_t                 mode [NCHAN];
    logic [PWM_BITS-1:0]   duty [NCHAN];

    logic                  chan_ok;
    logic                  blink_gate;
    logic                  heart_gate;
    logic [2:0]            blink_top;
    logic [NCHAN-1:0]      gate;
    logic [NCHAN-1:0]      pwm_on;
    logic [NCHAN-1:0]      led_next;
    logic                  cfg_ack_r;
    logic                  cfg_err_r;
    logic [NCHAN-1:0]      led_r;

    // Channel index is 4 bits wide; widen to 5 so NCHAN=16 compares correctly.
    assign chan_ok    = ({1'b0, bus.cfg_chan} < 5'(NCHAN));
    assign blink_top  = blink_ctr[BLINK_BITS-1 -: 3];
    assign blink_gate = ~blink_ctr[BLINK_BITS-1];
    assign heart_gate = (blink_top == 3'b000) || (blink_top == 3'b010);

    always_comb begin
        gate     = '0;
        pwm_on   = '0;
        led_next = '0;
        for (int c = 0; c < NCHAN; c++) begin
            case (mode[c])
                MODE_STEADY: gate[c] = 1'b1;
                MODE_BLINK:  gate[c] = blink_gate;
                MODE_HEART:  gate[c] = heart_gate;
                default:     gate[c] = 1'b0;
            endcase
            pwm_on[c]   = (pwm_ctr <= duty[c]);
            led_next[c] = (gate[c] & pwm_on[c]) ^ ACTIVE_LOW[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_ctr   <= '0;
            blink_ctr <= '0;
            cfg_ack_r <= 1'b0;
            cfg_err_r <= 1'b0;
            led_r     <= ACTIVE_LOW;
            for (int c = 0; c < NCHAN; c++) begin
                mode[c] <= MODE_OFF;
                duty[c] <= '1;
            end
        end else begin
            if (bus.sync) begin
                pwm_ctr   <= '0;
                blink_ctr <= '0;
            end else begin
                pwm_ctr   <= pwm_ctr + PWM_BITS'(1);
                blink_ctr <= blink_ctr + BLINK_BITS'(1);
            end

            cfg_ack_r <= bus.cfg_we & chan_ok;
            cfg_err_r <= bus.cfg_we & ~chan_ok;

            // Loop-compare instead of indexing so an out-of-range channel touches nothing.
            for (int c = 0; c < NCHAN; c++) begin
                if (bus.cfg_we && chan_ok && (bus.cfg_chan == 4'(c))) begin
                    mode[c] <= mode_t'(bus.cfg_mode);
                    duty[c] <= bus.cfg_duty;
                end
            end

            led_r <= led_next;
        end
    end

    assign bus.cfg_ack = cfg_ack_r;
    assign bus.cfg_err = cfg_err_r;
    assign bus.led     = led_r;

endmodule

// File: tb/tb_hd44780_led_indicator.sv
// Directed bench for the LED indicator: reset, table of config writes, pattern and
// PWM checks after sync alignment, invalid channel, and sync/reset coincident with a write.
module tb_hd44780_led_indicator;

    localparam int               NCHAN = 4;
    localparam int               PWM_B = 3;
    localparam int               BLK_B = 6;
    localparam logic [NCHAN-1:0] POL   = 4'b1000;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    hd44780_led_indicator_if #(.NCHAN(NCHAN), .PWM_BITS(PWM_B)) bus ();

    hd44780_led_indicator #(
        .NCHAN(NCHAN), .PWM_BITS(PWM_B), .BLINK_BITS(BLK_B), .ACTIVE_LOW(POL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] chan;
        logic [1:0] mode;
        logic [2:0] duty;
        logic       exp_ack;
        logic       exp_err;
    } wr_vec_t;

    wr_vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.sync     = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_chan = 4'd0;
        bus.cfg_mode = 2'b00;
        bus.cfg_duty = 3'd0;
    endtask

    // p is the counter value the LED register sampled; pwm = p mod 8, blink = p mod 64.
    function automatic logic [3:0] exp_led(input int p, input logic ch0_blink);
        int         pw;
        int         bl;
        logic [3:0] on;
        pw    = p % 8;
        bl    = p % 64;
        on[0] = ch0_blink ? (bl < 32) : (pw == 0);
        on[1] = 1'b1;
        on[2] = (bl < 32);
        on[3] = (bl < 8) || ((bl >= 16) && (bl < 24));
        return on ^ POL;
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        vecs[0] = '{chan: 4'd0,  mode: 2'b01, duty: 3'd0, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[1] = '{chan: 4'd1,  mode: 2'b01, duty: 3'd7, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[2] = '{chan: 4'd2,  mode: 2'b10, duty: 3'd7, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[3] = '{chan: 4'd3,  mode: 2'b11, duty: 3'd7, exp_ack: 1'b1, exp_err: 1'b0};
        vecs[4] = '{chan: 4'd5,  mode: 2'b00, duty: 3'd0, exp_ack: 1'b0, exp_err: 1'b1};
        vecs[5] = '{chan: 4'd15, mode: 2'b00, duty: 3'd0, exp_ack: 1'b0, exp_err: 1'b1};

        // Reset: two cycles held, then everything dark for 100 cycles.
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        check("reset_led", 32'(bus.led), 32'(POL));
        check("reset_ack", 32'(bus.cfg_ack), 32'd0);
        check("reset_err", 32'(bus.cfg_err), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_dark", 32'(bus.led), 32'(POL));
        end

        // Back-to-back writes from the table, one per cycle.
        for (int i = 0; i < 6; i++) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_chan = vecs[i].chan;
            bus.cfg_mode = vecs[i].mode;
            bus.cfg_duty = vecs[i].duty;
            tick();
            check($sformatf("wr%0d_ack", i), 32'(bus.cfg_ack), 32'(vecs[i].exp_ack));
            check($sformatf("wr%0d_err", i), 32'(bus.cfg_err), 32'(vecs[i].exp_err));
        end
        drive_idle();
        tick();
        check("wr_idle_ack", 32'(bus.cfg_ack), 32'd0);
        check("wr_idle_err", 32'(bus.cfg_err), 32'd0);

        // Sync pulse; afterwards edge j samples counter value j-1.
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        for (int j = 1; j <= 128; j++) begin
            if (j == 40) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_chan = 4'd5;
                bus.cfg_mode = 2'b00;
                bus.cfg_duty = 3'd0;
            end else begin
                drive_idle();
            end
            tick();
            check($sformatf("pattern_j%0d", j), 32'(bus.led), 32'(exp_led(j - 1, 1'b0)));
            if (j == 40) begin
                check("bad_chan_err", 32'(bus.cfg_err), 32'd1);
                check("bad_chan_ack", 32'(bus.cfg_ack), 32'd0);
            end
            if (j == 41) begin
                check("bad_chan_err_off", 32'(bus.cfg_err), 32'd0);
            end
        end
        drive_idle();

        // Write ch0 to blink coincident with sync.
        bus.sync     = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_chan = 4'd0;
        bus.cfg_mode = 2'b10;
        bus.cfg_duty = 3'd7;
        tick();
        drive_idle();
        check("sync_wr_ack", 32'(bus.cfg_ack), 32'd1);
        check("sync_wr_err", 32'(bus.cfg_err), 32'd0);
        for (int j = 1; j <= 34; j++) begin
            tick();
            check($sformatf("sync_blink_j%0d", j), 32'(bus.led), 32'(exp_led(j - 1, 1'b1)));
            if (j == 1) begin
                check("sync_ack_gone", 32'(bus.cfg_ack), 32'd0);
            end
        end

        // Same write coincident with reset: discarded, no ack, all dark.
        rst          = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_chan = 4'd0;
        bus.cfg_mode = 2'b10;
        bus.cfg_duty = 3'd7;
        tick();
        check("rst_wr_ack", 32'(bus.cfg_ack), 32'd0);
        check("rst_wr_err", 32'(bus.cfg_err), 32'd0);
        check("rst_wr_led", 32'(bus.led), 32'(POL));
        rst = 1'b0;
        drive_idle();
        for (int j = 1; j <= 40; j++) begin
            tick();
            check("post_rst_ack", 32'(bus.cfg_ack), 32'd0);
            check("post_rst_led", 32'(bus.led), 32'(POL));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hd44780_led_indicator.md
HD44780_LED_INDICATOR -- requirements
Module: hd44780_led_indicator

Interface
REQ-001 SHALL have parameter NCHAN, default 4, number of LED channels (1..16).
REQ-002 SHALL have parameter PWM_BITS, default 3, brightness counter width (1..8).
REQ-003 SHALL have parameter BLINK_BITS, default `H4_TIMER_BITS+4, blink/pattern counter width (>=4).
REQ-004 SHALL have parameter ACTIVE_LOW, default {NCHAN{1'b0}}, per-channel output polarity mask (1 = active-low pin).
REQ-005 SHALL provide the following ports:
- CLK_I  in  1  system clock; the block has one clock.
- RST_I  in  1  reset; synchronous, active-high.
- sync_i  in  1  pulse; restarts both counters for phase alignment.
- cfg_we_i  in  1  configuration write strobe.
- cfg_chan_i  in  4  target channel index.
- cfg_mode_i  in  2  mode: 00 off, 01 steady, 10 blink, 11 heartbeat.
- cfg_duty_i  in  PWM_BITS  brightness code.
- cfg_ack_o  out  1  one-cycle write-accepted pulse.
- cfg_err_o  out  1  one-cycle write-rejected pulse.
- led_o  out  NCHAN  registered LED drive, polarity per ACTIVE_LOW.

Function
REQ-006 SHALL run a free-running PWM_BITS counter pwm_ctr, +1 per cycle, wrapping from all-ones to 0.
REQ-007 SHALL run a free-running BLINK_BITS counter blink_ctr, +1 per cycle, wrapping from all-ones to 0.
REQ-008 SHALL, when sync_i=1, load 0 into both counters at that edge, overriding the increment.
REQ-009 SHALL define pwm_on[c] = (pwm_ctr <= duty[c]), unsigned compare:
- duty 0 gives 1/2^PWM_BITS of the cycles.
- all-ones duty gives 100%.
REQ-010 SHALL define the pattern gate per channel:
- off: 0.
- steady: 1.
- blink: ~blink_ctr[BLINK_BITS-1].
- heartbeat: 1 when blink_ctr[BLINK_BITS-1:BLINK_BITS-3] is 3'b000 or 3'b010, else 0.
REQ-011 SHALL register led_o[c] = (gate[c] & pwm_on[c]) ^ ACTIVE_LOW[c] each cycle, computed from the current-cycle counters and config.
REQ-012 SHALL accept a write when cfg_we_i=1 and cfg_chan_i<NCHAN:
- mode[cfg_chan_i] and duty[cfg_chan_i] update at that edge.
- cfg_ack_o=1 for the following cycle only.
REQ-013 SHALL reject a write when cfg_we_i=1 and cfg_chan_i>=NCHAN:
- no configuration state changes.
- cfg_err_o=1 for the following cycle only.
REQ-014 SHALL make an accepted write visible on led_o at the second edge after the write edge (write at edge k, led_o reflects the new config after edge k+1).
REQ-015 SHALL accept back-to-back writes every cycle with no throughput loss; each write gets its own ack/err pulse.
REQ-016 SHALL, when sync_i and cfg_we_i coincide, perform both actions in the same edge.
REQ-017 SHALL leave other channels' outputs undisturbed by a write to one channel.
REQ-018 SHALL never assert cfg_ack_o and cfg_err_o in the same cycle.

Reset
REQ-019 SHALL, while RST_I=1 at an edge, set:
- pwm_ctr=0 and blink_ctr=0.
- all modes=off and all duty=all-ones.
- cfg_ack_o=0 and cfg_err_o=0.
- led_o=ACTIVE_LOW (every LED dark).
REQ-020 SHALL give RST_I priority over sync_i and cfg_we_i; a write coincident with reset is discarded and not acknowledged.
REQ-021 SHALL, on reset asserted mid-operation, return to the REQ-019 state at that edge with no residual pulses.

Verification (NCHAN=4, PWM_BITS=3, BLINK_BITS=6, ACTIVE_LOW=4'b1000)
REQ-022 SHALL check reset:
- Stimulus: hold RST_I 2 cycles, then release.
- Response: led_o=4'b1000, ack/err=0, and outputs stay dark for 100 cycles.
REQ-023 SHALL check steady mode and PWM duty:
- Stimulus: write ch0 mode 01 duty 0; write ch1 mode 01 duty 7.
- Response: led_o[0] high exactly 1 of every 8 cycles; led_o[1] constantly high after the 2-cycle latency; ack pulses 2 cycles.
REQ-024 SHALL check blink, heartbeat and sync alignment:
- Stimulus: write ch2 mode 10 duty 7; write ch3 mode 11 duty 7; pulse sync_i.
- Response: led_o[2] is high 32 cycles then low 32 cycles; led_o[3] is low (active) for cycles 0-7 and 16-23 of each 64-cycle period, else high.
REQ-025 SHALL check an invalid channel:
- Stimulus: write cfg_chan_i=5.
- Response: cfg_err_o pulses 1 cycle; no ack; led_o unchanged.
REQ-026 SHALL check simultaneous events:
- Stimulus: write ch0 mode 10 duty 7 in the same cycle as sync_i.
- Response: ack next cycle; led_o[0] high from edge k+1 through 32 cycles.
- Stimulus: repeat the write with RST_I=1.
- Response: no ack; led_o=4'b1000.
